sequencer: RTL and testbench
============================

Name: sequencer

Overview:
- Control FSM that drives the SequencerState `q` consumed by the core.
- Steps each instruction through fetch, operand load, calc, write-back and IP advance.
- Adds run/single-step/halt control, a one-address breakpoint, RAM-busy stalls and a stall watchdog.
- Sits between the debug/host control inputs and the core; it is the core's only source of `q`.

Parameters:
- OPCODE_WIDTH, 8, width of `opcode` (from shared package).
- IP_WIDTH, 8, width of `ip` and `bp_addr` (from shared package).
- CNT_WIDTH, 16, width of the retired-instruction counter.
- STALL_LIMIT, 255, maximum consecutive `ram_busy` stall cycles before a fault.
- HALT_OPCODE, 8'hFF, opcode that halts after its write-back.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- run  in  1  pulse: start or resume free-running execution
- step  in  1  pulse: execute exactly one instruction, then halt
- halt_req  in  1  pulse: halt at the next instruction boundary
- ram_busy  in  1  RAM not ready; stalls load, calc and write states
- opcode  in  OPCODE_WIDTH  current instruction opcode from instruction memory
- ip  in  IP_WIDTH  current instruction pointer from the core
- bp_en  in  1  breakpoint enable
- bp_addr  in  IP_WIDTH  breakpoint IP
- q  out  SequencerState  current state
- halted  out  1  high in SRST and SHALT
- halt_cause  out  2  0 none / reset, 1 halt opcode or halt_req or step done, 2 breakpoint, 3 watchdog fault
- retired  out  CNT_WIDTH  instructions completed; saturates at all-ones

Behaviour:
- Reset values (rst=1 at a clk edge):
  - q=SRST, halt_cause=0, retired=0.
  - Internal state cleared: step_mode=0, halt_pend=0, bp_skip=0, stall_cnt=0.
  - halted=1 after reset.
  - Reset mid-instruction aborts immediately; no partial state is kept.
- All state is registered; q changes only on clk edges; halted is decoded from q.
- Normal path, one state per cycle: SREAD -> SLOAD1 -> SLOAD2 -> SLOAD3 -> SCALC -> SWRITE -> SNXT -> SREAD.
- SRST:
  - run -> SREAD with step_mode=0.
  - step -> SREAD with step_mode=1.
  - run and step together: run wins.
  - halt_req is ignored.
- SREAD: if bp_en && ip==bp_addr && !bp_skip -> SHALT with cause=2; otherwise -> SLOAD1. bp_skip clears when leaving SREAD.
- Stalls in SLOAD1, SLOAD2, SLOAD3, SCALC and SWRITE:
  - If ram_busy=1, hold q and increment stall_cnt.
  - Else advance and clear stall_cnt.
  - If stall_cnt reaches STALL_LIMIT while ram_busy=1, go to SHALT with cause=3.
- SNXT:
  - retired increments by 1 (saturating).
  - Next state is SHALT if opcode==HALT_OPCODE, halt_pend=1, or step_mode=1, with cause=1.
  - Otherwise next state is SREAD.
- halt_req: latched into halt_pend in any non-halted state; cleared on entry to SHALT.
- SHALT:
  - run -> SREAD with step_mode=0, bp_skip=1, cause=0.
  - step -> SREAD with step_mode=1, bp_skip=1, cause=0.
  - run and step together: run wins.
  - Otherwise hold. halt_req has no effect.
- Priority at SNXT when several halt conditions hold: the single cause value is 1.
- Fault (cause=3) is cleared only by run, step or rst.
- The core derives its enables from q with one register stage, so the sequencer adds no extra latency.
- Fault-free instruction length is 7 cycles plus stall cycles.

Decomposition:
- Shared package (params.svh):
  - SequencerState enum extended with SHALT (encoding appended after SNXT; the core's default branch keeps all enables off in SHALT).
  - HALT_OPCODE constant.
  - HaltCause enum.
  - OPCODE_WIDTH and IP_WIDTH.
- One natural sub-module: stall_watchdog (counter, clear, limit compare, expired flag).

Test Plan:
- rst, then run pulse, opcode=8'h01, ram_busy=0: q sequence SRST, SREAD, SLOAD1, SLOAD2, SLOAD3, SCALC, SWRITE, SNXT, SREAD; retired=1 after 8 cycles; halted=0.
- step pulse from SRST: one full instruction; SNXT -> SHALT; halted=1, cause=1, retired=1; a second step executes exactly one more (retired=2).
- bp_en=1, bp_addr=8'h03, run, ip reaches 8'h03: SREAD -> SHALT, cause=2; run resumes past the breakpoint (SREAD -> SLOAD1, no re-halt).
- ram_busy held high 3 cycles in SLOAD2: q stays SLOAD2 for 4 cycles total, then advances; retired unaffected.
- ram_busy held high permanently in SWRITE, STALL_LIMIT=4: SHALT with cause=3 after 4 stall cycles; run clears cause.
- halt_req pulse during SLOAD1 plus an opcode==8'hFF instruction: halts at SNXT with cause=1; rst asserted in SCALC -> next q=SRST, retired=0.

Source files
------------

// File: rtl/sequencer_pkg.sv
// Shared sequencer types: state encoding, halt causes and core-wide widths.
// SHALT is appended after SNXT so the core's default decode keeps all enables off there.
package sequencer_pkg;

  localparam int OPCODE_WIDTH = 8;
  localparam int IP_WIDTH     = 8;

  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 8'hFF;

  typedef enum logic [3:0] {
    SRST   = 4'd0,
    SREAD  = 4'd1,
    SLOAD1 = 4'd2,
    SLOAD2 = 4'd3,
    SLOAD3 = 4'd4,
    SCALC  = 4'd5,
    SWRITE = 4'd6,
    SNXT   = 4'd7,
    SHALT  = 4'd8
  } sequencer_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_HALT  = 2'd1,
    CAUSE_BP    = 2'd2,
    CAUSE_FAULT = 2'd3
  } halt_cause_t;

  function automatic logic is_stall_state(input sequencer_state_t s);
    logic r;
    r = (s == SLOAD1) || (s == SLOAD2) || (s == SLOAD3) || (s == SCALC) || (s == SWRITE);
    return r;
  endfunction

  function automatic sequencer_state_t advance(input sequencer_state_t s);
    sequencer_state_t n;
    case (s)
      SLOAD1:  n = SLOAD2;
      SLOAD2:  n = SLOAD3;
      SLOAD3:  n = SCALC;
      SCALC:   n = SWRITE;
      SWRITE:  n = SNXT;
      default: n = SRST;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sequencer_if.sv
// Control/status bundle between host+core and the sequencer.
// master = host/core side driving controls; slave = sequencer producing state.
interface sequencer_if
  import sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) ();

  logic                    run;
  logic                    step;
  logic                    halt_req;
  logic                    ram_busy;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [IP_WIDTH-1:0]     ip;
  logic                    bp_en;
  logic [IP_WIDTH-1:0]     bp_addr;
  sequencer_state_t        q;
  logic                    halted;
  logic [1:0]              halt_cause;
  logic [CNT_WIDTH-1:0]    retired;

  modport master (
    output run, step, halt_req, ram_busy, opcode, ip, bp_en, bp_addr,
    input  q, halted, halt_cause, retired
  );

  modport slave (
    input  run, step, halt_req, ram_busy, opcode, ip, bp_en, bp_addr,
    output q, halted, halt_cause, retired
  );

endinterface

// File: rtl/sequencer_stall_watchdog.sv
// Counts consecutive busy cycles in stall-capable states; expired fires combinationally on the
// busy cycle that brings the count to STALL_LIMIT, and the counter clears whenever the stall ends.
module sequencer_stall_watchdog #(
  parameter int STALL_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic busy,
  output logic expired
);

  localparam int CW = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    expired = active && busy && (cnt_q >= CW'(STALL_LIMIT - 1));
    cnt_d   = '0;
    if (active && busy && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sequencer.sv
// Instruction sequencer FSM: fetch/load/calc/write/next, with run/step/halt, breakpoint and stall watchdog.
// One state per cycle, 7 cycles per instruction plus ram_busy stalls; q is registered.
module sequencer #(
  parameter int                                   CNT_WIDTH   = 16,
  parameter int                                   STALL_LIMIT = 255,
  parameter logic [sequencer_pkg::OPCODE_WIDTH-1:0] HALT_OPCODE = sequencer_pkg::HALT_OPCODE
) (
  input  logic           clk,
  input  logic           rst,
  sequencer_if.slave     bus
);

  import sequencer_pkg::*;

  sequencer_state_t     q_q, q_d;
  halt_cause_t          cause_q, cause_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 step_mode_q, step_mode_d;
  logic                 halt_pend_q, halt_pend_d;
  logic                 bp_skip_q, bp_skip_d;
  logic                 wd_expired;
  logic                 bp_hit;
  logic                 halt_at_nxt;

  sequencer_stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .active  (is_stall_state(q_q)),
    .busy    (bus.ram_busy),
    .expired (wd_expired)
  );

  assign bp_hit      = bus.bp_en && (bus.ip == bus.bp_addr) && !bp_skip_q;
  assign halt_at_nxt = (bus.opcode == HALT_OPCODE) || halt_pend_q || step_mode_q;

  always_comb begin
    q_d         = q_q;
    cause_d     = cause_q;
    retired_d   = retired_q;
    step_mode_d = step_mode_q;
    halt_pend_d = halt_pend_q;
    bp_skip_d   = bp_skip_q;

    if ((q_q != SRST) && (q_q != SHALT) && bus.halt_req) begin
      halt_pend_d = 1'b1;
    end

    case (q_q)
      SRST, SHALT: begin
        // run beats step; leaving SHALT arms bp_skip so we can step off the breakpoint
        if (bus.run || bus.step) begin
          q_d         = SREAD;
          step_mode_d = !bus.run;
          bp_skip_d   = (q_q == SHALT);
          cause_d     = CAUSE_NONE;
        end
      end
      SREAD: begin
        bp_skip_d = 1'b0;
        if (bp_hit) begin
          q_d     = SHALT;
          cause_d = CAUSE_BP;
        end else begin
          q_d = SLOAD1;
        end
      end
      SLOAD1, SLOAD2, SLOAD3, SCALC, SWRITE: begin
        if (wd_expired) begin
          q_d     = SHALT;
          cause_d = CAUSE_FAULT;
        end else if (!bus.ram_busy) begin
          q_d = advance(q_q);
        end
      end
      SNXT: begin
        if (retired_q != '1) begin
          retired_d = retired_q + CNT_WIDTH'(1);
        end
        if (halt_at_nxt) begin
          q_d     = SHALT;
          cause_d = CAUSE_HALT;
        end else begin
          q_d = SREAD;
        end
      end
      default: begin
        q_d = SRST;
      end
    endcase

    if ((q_d == SHALT) && (q_q != SHALT)) begin
      halt_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q         <= SRST;
      cause_q     <= CAUSE_NONE;
      retired_q   <= '0;
      step_mode_q <= 1'b0;
      halt_pend_q <= 1'b0;
      bp_skip_q   <= 1'b0;
    end else begin
      q_q         <= q_d;
      cause_q     <= cause_d;
      retired_q   <= retired_d;
      step_mode_q <= step_mode_d;
      halt_pend_q <= halt_pend_d;
      bp_skip_q   <= bp_skip_d;
    end
  end

  assign bus.q          = q_q;
  assign bus.halted     = (q_q == SRST) || (q_q == SHALT);
  assign bus.halt_cause = cause_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_sequencer.sv
// Directed scoreboard bench for sequencer: each driven cycle queues the expected
// post-edge state; an independent monitor pops and compares after every clock edge.
module tb_sequencer;
  import sequencer_pkg::*;

  typedef struct packed {
    sequencer_state_t q;
    logic             halted;
    logic [1:0]       cause;
    logic [15:0]      retired;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   mon_cyc;
  exp_t exp_q[$];

  sequencer_if #(.CNT_WIDTH(16)) bus ();

  sequencer #(
    .CNT_WIDTH   (16),
    .STALL_LIMIT (4),
    .HALT_OPCODE (8'hFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: sample 2 time units after each rising edge, compare to the oldest expectation.
  initial begin
    exp_t e;
    exp_t g;
    mon_cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      mon_cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g.q       = bus.q;
        g.halted  = bus.halted;
        g.cause   = bus.halt_cause;
        g.retired = bus.retired;
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL cyc%0d state: got q=%0d halted=%0b cause=%0d retired=%0d, want q=%0d halted=%0b cause=%0d retired=%0d",
                   mon_cyc, g.q, g.halted, g.cause, g.retired, e.q, e.halted, e.cause, e.retired);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick(input sequencer_state_t s, input logic [1:0] c, input int r);
    exp_t e;
    e.q       = s;
    e.halted  = (s == SRST) || (s == SHALT);
    e.cause   = c;
    e.retired = 16'(r);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.run      = 1'b0;
    bus.step     = 1'b0;
    bus.halt_req = 1'b0;
  endtask

  // SLOAD1..SNXT with no stalls, cause 0, retired unchanged until leaving SNXT.
  task automatic body(input int r);
    tick(SLOAD1, 2'd0, r);
    tick(SLOAD2, 2'd0, r);
    tick(SLOAD3, 2'd0, r);
    tick(SCALC,  2'd0, r);
    tick(SWRITE, 2'd0, r);
    tick(SNXT,   2'd0, r);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst          = 1'b1;
    bus.run      = 1'b0;
    bus.step     = 1'b0;
    bus.halt_req = 1'b0;
    bus.ram_busy = 1'b0;
    bus.opcode   = 8'h01;
    bus.ip       = 8'h00;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 8'h00;

    // Reset and idle; halt_req in SRST must not be latched
    tick(SRST, 2'd0, 0);
    tick(SRST, 2'd0, 0);
    rst = 1'b0;
    tick(SRST, 2'd0, 0);
    bus.halt_req = 1'b1;
    tick(SRST, 2'd0, 0);

    // Free run, first instruction retires after 8 edges
    bus.run = 1'b1;
    tick(SREAD, 2'd0, 0);
    body(0);
    tick(SREAD, 2'd0, 1);

    // Three busy cycles in SLOAD2
    tick(SLOAD1, 2'd0, 1);
    tick(SLOAD2, 2'd0, 1);
    bus.ram_busy = 1'b1;
    tick(SLOAD2, 2'd0, 1);
    tick(SLOAD2, 2'd0, 1);
    tick(SLOAD2, 2'd0, 1);
    bus.ram_busy = 1'b0;
    tick(SLOAD3, 2'd0, 1);
    tick(SCALC,  2'd0, 1);
    tick(SWRITE, 2'd0, 1);
    tick(SNXT,   2'd0, 1);
    tick(SREAD,  2'd0, 2);

    // halt_req pulse in SLOAD1 halts at the instruction boundary
    tick(SLOAD1, 2'd0, 2);
    bus.halt_req = 1'b1;
    tick(SLOAD2, 2'd0, 2);
    tick(SLOAD3, 2'd0, 2);
    tick(SCALC,  2'd0, 2);
    tick(SWRITE, 2'd0, 2);
    tick(SNXT,   2'd0, 2);
    tick(SHALT,  2'd1, 3);
    tick(SHALT,  2'd1, 3);
    bus.halt_req = 1'b1;
    tick(SHALT,  2'd1, 3);

    // Resume: pending halt was cleared on entry to SHALT
    bus.run = 1'b1;
    tick(SREAD, 2'd0, 3);
    body(3);
    tick(SREAD, 2'd0, 4);

    // Halt opcode
    bus.opcode = 8'hFF;
    body(4);
    tick(SHALT, 2'd1, 5);
    bus.opcode = 8'h01;

    // Two single steps
    bus.step = 1'b1;
    tick(SREAD, 2'd0, 5);
    body(5);
    tick(SHALT, 2'd1, 6);
    bus.step = 1'b1;
    tick(SREAD, 2'd0, 6);
    body(6);
    tick(SHALT, 2'd1, 7);

    // run+step together: run wins, keeps running
    bus.run  = 1'b1;
    bus.step = 1'b1;
    tick(SREAD, 2'd0, 7);
    body(7);
    tick(SREAD, 2'd0, 8);

    // Breakpoint at 8'h03
    bus.bp_en   = 1'b1;
    bus.bp_addr = 8'h03;
    bus.ip      = 8'h02;
    body(8);
    tick(SREAD, 2'd0, 9);
    bus.ip = 8'h03;
    tick(SHALT, 2'd2, 9);
    tick(SHALT, 2'd2, 9);
    bus.run = 1'b1;
    tick(SREAD, 2'd0, 9);
    body(9);
    tick(SREAD, 2'd0, 10);
    tick(SHALT, 2'd2, 10);
    bus.bp_en = 1'b0;
    bus.run   = 1'b1;
    tick(SREAD, 2'd0, 10);

    // Watchdog: permanent busy in SWRITE faults after 4 stall cycles
    tick(SLOAD1, 2'd0, 10);
    tick(SLOAD2, 2'd0, 10);
    tick(SLOAD3, 2'd0, 10);
    tick(SCALC,  2'd0, 10);
    tick(SWRITE, 2'd0, 10);
    bus.ram_busy = 1'b1;
    tick(SWRITE, 2'd0, 10);
    tick(SWRITE, 2'd0, 10);
    tick(SWRITE, 2'd0, 10);
    tick(SHALT,  2'd3, 10);
    tick(SHALT,  2'd3, 10);
    bus.ram_busy = 1'b0;
    tick(SHALT,  2'd3, 10);
    bus.run = 1'b1;
    tick(SREAD, 2'd0, 10);

    // Counter restarted after the fault: three stalls do not fault
    tick(SLOAD1, 2'd0, 10);
    bus.ram_busy = 1'b1;
    tick(SLOAD1, 2'd0, 10);
    tick(SLOAD1, 2'd0, 10);
    tick(SLOAD1, 2'd0, 10);
    bus.ram_busy = 1'b0;
    tick(SLOAD2, 2'd0, 10);
    tick(SLOAD3, 2'd0, 10);
    tick(SCALC,  2'd0, 10);
    tick(SWRITE, 2'd0, 10);
    tick(SNXT,   2'd0, 10);
    tick(SREAD,  2'd0, 11);

    // Reset mid-instruction in SCALC
    tick(SLOAD1, 2'd0, 11);
    tick(SLOAD2, 2'd0, 11);
    tick(SLOAD3, 2'd0, 11);
    tick(SCALC,  2'd0, 11);
    rst = 1'b1;
    tick(SRST, 2'd0, 0);
    rst = 1'b0;
    tick(SRST, 2'd0, 0);
    bus.run = 1'b1;
    tick(SREAD, 2'd0, 0);
    body(0);
    tick(SREAD, 2'd0, 1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
